// File: rtl/edge_result_writer.sv
// Result sink for the edge-detection datapath: buffers filter output in a
// small FIFO and streams it into the result SRAM in raster order.
module edge_result_writer #(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_pixel,
    input  logic              bin_en,
    input  logic [7:0]        thresh,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              wen,
    output logic [7:0]        d,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   pix_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FW    = PTR_W + 1;
    localparam int CW    = ADDR_W + 1;

    localparam logic [PTR_W:0]    PTR_ONE  = FW'(1);
    localparam logic [PTR_W:0]    FULL_LVL = FW'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = CW'(1);
    localparam logic [ADDR_W:0]   LAST_PIX = CW'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] ADR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    // extra pointer bit tells a full FIFO apart from an empty one
    logic [PTR_W:0]    rd_ptr, wr_ptr, fill;
    logic [ADDR_W-1:0] wr_addr;
    logic              fifo_empty, fifo_full;
    logic              run, launch, pop, push, drop, frame_last;
    logic [7:0]        bin_pix, push_data;

    assign fill       = wr_ptr - rd_ptr;
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == FULL_LVL);

    assign run        = (state == S_RUN);
    assign launch     = (state == S_IDLE) && start;
    assign pop        = (run || state == S_DRAIN) && !fifo_empty && mem_ready;
    assign push       = run && in_valid && (!fifo_full || pop);
    assign drop       = run && in_valid && fifo_full && !pop;
    assign frame_last = push && (pix_count == LAST_PIX);

    assign bin_pix    = (in_pixel >= thresh) ? 8'hFF : 8'h00;
    assign push_data  = bin_en ? bin_pix : in_pixel;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (frame_last) state_nx = S_DRAIN;
            S_DRAIN: if (fifo_empty) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            wr_addr   <= '0;
            pix_count <= '0;
            overflow  <= 1'b0;
            addr      <= '0;
            wen       <= 1'b1;
            d         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == S_RUN) || (state_nx == S_DRAIN);
            done  <= (state == S_DRAIN) && (state_nx == S_DONE);
            wen   <= !pop;
            if (pop) begin
                addr <= wr_addr;
                d    <= fifo_mem[rd_ptr[PTR_W-1:0]];
            end
            if (launch) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                wr_addr   <= '0;
                pix_count <= '0;
                overflow  <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr    <= wr_ptr + PTR_ONE;
                    pix_count <= pix_count + CNT_ONE;
                end
                if (pop) begin
                    rd_ptr  <= rd_ptr + PTR_ONE;
                    wr_addr <= wr_addr + ADR_ONE;
                end
                if (drop) overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_edge_result_writer.sv
// Randomized scoreboard bench for edge_result_writer on a 4x4 frame.
module tb_edge_result_writer;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int NPIX   = IMG_W * IMG_H;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_pixel = 8'd0;
    logic              bin_en = 1'b0;
    logic [7:0]        thresh = 8'd0;
    logic              mem_ready = 1'b0;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [7:0]        d;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W:0]   pix_count;

    edge_result_writer #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .ADDR_W(ADDR_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .in_valid(in_valid),
        .in_pixel(in_pixel),
        .bin_en(bin_en),
        .thresh(thresh),
        .mem_ready(mem_ready),
        .addr(addr),
        .wen(wen),
        .d(d),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [7:0]        v;
    } wr_t;

    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  frames = 0;
    int  first_wr_cyc = -1;
    int  first_valid_cyc = 0;
    bit  prev_wen = 1'b1;

    wr_t exp_q[$];
    int  m_occ, m_count, m_addr;
    bit  m_active, m_busy, m_done, m_ovf, m_fin, m_wen;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_pix(input logic [7:0] p,
                                           input logic b,
                                           input logic [7:0] t);
        if (!b) return p;
        return (int'(p) >= int'(t)) ? 8'd255 : 8'd0;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_occ = 0; m_count = 0; m_addr = 0;
        m_active = 0; m_busy = 0; m_done = 0;
        m_ovf = 0; m_fin = 0; m_wen = 1;
    endtask

    // Frame-level reference: occupancy count, accepted pixel count, drops.
    task automatic model_step();
        bit  pop, push, take_start, in_run;
        wr_t e;
        take_start = start && !m_busy && !m_done;
        m_done = 0;
        if (m_fin) begin
            m_busy = 0;
            m_done = 1;
            m_fin  = 0;
        end
        in_run = m_active && (m_count < NPIX);
        pop    = m_active && (m_occ > 0) && mem_ready;
        push   = in_run && in_valid && ((m_occ < DEPTH) || pop);
        m_wen  = !pop;
        if (pop) m_occ--;
        if (push) begin
            e.a = ADDR_W'(m_addr);
            e.v = ref_pix(in_pixel, bin_en, thresh);
            exp_q.push_back(e);
            m_occ++;
            m_addr++;
            m_count++;
        end else if (in_run && in_valid) begin
            m_ovf = 1;
        end
        if (pop && m_count == NPIX && m_occ == 0) begin
            m_active = 0;
            m_fin    = 1;
        end
        if (take_start) begin
            m_active = 1; m_busy = 1;
            m_count = 0; m_occ = 0; m_addr = 0; m_ovf = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (rst_n) model_step();
    end

    initial forever begin : monitor
        wr_t e;
        @(negedge clk);
        if (rst_n) begin
            chk("wen", int'(wen), int'(m_wen));
            chk("busy", int'(busy), int'(m_busy));
            chk("done", int'(done), int'(m_done));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("pix_count", int'(pix_count), m_count);
            if (!wen) begin
                chk("write_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("addr", int'(addr), int'(e.a));
                    chk("d", int'(d), int'(e.v));
                end
                wr_cnt++;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                chk("done_after_write", int'(prev_wen), 0);
                chk("done_queue_empty", exp_q.size(), 0);
            end
            prev_wen = wen;
        end
    end

    task automatic drive(input bit s, input bit v, input logic [7:0] p,
                         input bit b, input logic [7:0] t, input bit mr);
        @(negedge clk);
        start = s; in_valid = v; in_pixel = p;
        bin_en = b; thresh = t; mem_ready = mr;
    endtask

    task automatic start_frame();
        drive(1, 0, 8'd0, 0, 8'd0, 1);
        frames++;
        drive(0, 0, 8'd0, 0, 8'd0, 1);
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            drive(0, 0, 8'd0, 0, 8'd0, 1);
            n++;
        end
        chk("done_seen", int'(done_cnt != d0), 1);
        drive(0, 0, 8'd0, 0, 8'd0, 1);
        drive(0, 0, 8'd0, 0, 8'd0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n, w0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_addr", int'(addr), 0);
        chk("rst_wen", int'(wen), 1);
        chk("rst_d", int'(d), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_pix_count", int'(pix_count), 0);
        rst_n = 1'b1;

        // valid pulses while idle must not produce writes
        for (int i = 0; i < 3; i++) drive(0, 1, 8'(i + 40), 0, 8'd0, 1);
        drive(0, 0, 8'd0, 0, 8'd0, 1);
        chk("idle_pix_count", int'(pix_count), 0);

        // passthrough, with a stray start mid-frame
        start_frame();
        first_wr_cyc = -1;
        w0 = wr_cnt;
        for (int i = 0; i < NPIX; i++) begin
            drive(i == 5, 1, 8'(i), 0, 8'd0, 1);
            if (i == 0) first_valid_cyc = cyc;
        end
        wait_done(100);
        chk("latency", first_wr_cyc - first_valid_cyc, 2);
        chk("pass_writes", wr_cnt - w0, NPIX);
        chk("pass_pix_count", int'(pix_count), NPIX);
        chk("pass_overflow", int'(overflow), 0);

        // binarize boundary values, then random thresholds
        start_frame();
        drive(0, 1, 8'd127, 1, 8'd128, 1);
        drive(0, 1, 8'd128, 1, 8'd128, 1);
        drive(0, 1, 8'd255, 1, 8'd128, 1);
        drive(0, 1, 8'd0,   1, 8'd128, 1);
        for (int i = 4; i < NPIX; i++)
            drive(0, 1, 8'($urandom), 1'($urandom), 8'($urandom), 1);
        wait_done(100);

        // stall: six pixels into a four-entry FIFO
        start_frame();
        for (int i = 0; i < 6; i++) drive(0, 1, 8'(100 + i), 0, 8'd0, 0);
        drive(0, 0, 8'd0, 0, 8'd0, 0);
        chk("stall_pix_count", int'(pix_count), DEPTH);
        chk("stall_overflow", int'(overflow), 1);
        for (int i = DEPTH; i < NPIX; i++) drive(0, 1, 8'(150 + i), 0, 8'd0, 1);
        wait_done(100);

        // full FIFO with push and pop on the same edge
        start_frame();
        for (int i = 0; i < DEPTH; i++) drive(0, 1, 8'(60 + i), 0, 8'd0, 0);
        drive(0, 0, 8'd0, 0, 8'd0, 0);
        drive(0, 1, 8'd77, 0, 8'd0, 1);
        drive(0, 0, 8'd0, 0, 8'd0, 0);
        chk("fullpop_pix_count", int'(pix_count), DEPTH + 1);
        chk("fullpop_overflow", int'(overflow), 0);
        drive(0, 1, 8'd78, 0, 8'd0, 0);
        drive(0, 0, 8'd0, 0, 8'd0, 0);
        chk("still_full_overflow", int'(overflow), 1);
        chk("still_full_pix_count", int'(pix_count), DEPTH + 1);
        for (int i = DEPTH + 1; i < NPIX; i++) drive(0, 1, 8'(80 + i), 0, 8'd0, 1);
        wait_done(100);

        // random traffic and memory stalls
        for (int f = 0; f < 4; f++) begin
            start_frame();
            n = 0;
            while (m_count < NPIX && n < 500) begin
                drive(($urandom % 8) == 0, ($urandom % 4) != 0, 8'($urandom),
                      1'($urandom), 8'($urandom), ($urandom % 3) != 0);
                n++;
            end
            wait_done(200);
        end

        // reset in the middle of a frame
        start_frame();
        w0 = wr_cnt;
        n = 0;
        while (wr_cnt - w0 < 7 && n < 100) begin
            drive(0, 1, 8'(n + 30), 0, 8'd0, 1);
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wen", int'(wen), 1);
        chk("mid_rst_addr", int'(addr), 0);
        chk("mid_rst_pix_count", int'(pix_count), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        model_clear();
        in_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start_frame();
        for (int i = 0; i < NPIX; i++) drive(0, 1, 8'(200 + i), 0, 8'd0, 1);
        wait_done(100);

        chk("done_pulses", done_cnt, frames - 1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
